clock_digits_scheduler: RTL and testbench

//  Drives the shared num_to_pix glyph ROM bank for the HH:MM clock face.

---
 rtl/clock_digits_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_clock_digits_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_digits_scheduler.sv
// Glyph scheduler for the HH:MM clock face.
// Maps each scan pixel to one of four digit slots or the colon. Drives the
// glyph number and glyph-local X/Y to the shared num_to_pix ROM, and
// re-aligns the returned ROM bit with the scan stream. Digits are latched
// once per frame so that a frame never shows two different times, and
// digits under edit blink at a frame-counted rate.
module clock_digits_scheduler #(
    parameter int PIX_X_W      = 12,
    parameter int PIX_Y_W      = 12,
    parameter int NUM_W        = 4,
    parameter int DIG_W        = 80,
    parameter int DIG_H        = 120,
    parameter int DIG_GAP      = 32,
    parameter int ORG_X        = 100,
    parameter int ORG_Y        = 180,
    parameter int COLON_SZ     = 12,
    parameter int BLINK_FRAMES = 30,
    parameter int ROM_LAT      = 1,
    parameter bit LZ_SUPPRESS  = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_start_i,
    input  logic               pix_valid_i,
    input  logic [PIX_X_W-1:0] pix_x_i,
    input  logic [PIX_Y_W-1:0] pix_y_i,
    input  logic [15:0]        time_digits_i,
    input  logic               blink_en_i,
    input  logic [3:0]         blink_mask_i,
    output logic [NUM_W-1:0]   num_o,
    output logic [PIX_X_W-1:0] pos_x_o,
    output logic [PIX_Y_W-1:0] pos_y_o,
    input  logic               pix_i,
    output logic               pix_valid_o,
    output logic               pix_on_o,
    output logic               bcd_err_o
);

    localparam int SLOT_PITCH = DIG_W + DIG_GAP;
    localparam int CNT_W      = $clog2(BLINK_FRAMES + 1);

    // Colon dots sit centred in the gap between slots 1 and 2.
    localparam int COL_X0 = ORG_X + 2 * DIG_W + DIG_GAP + (DIG_GAP - COLON_SZ) / 2;
    localparam int COL_Y0 = ORG_Y + DIG_H / 3 - COLON_SZ / 2;
    localparam int COL_Y1 = ORG_Y + (2 * DIG_H) / 3 - COLON_SZ / 2;

    localparam logic [PIX_X_W-1:0] DIG_W_X   = PIX_X_W'(DIG_W);
    localparam logic [PIX_Y_W-1:0] DIG_H_Y   = PIX_Y_W'(DIG_H);
    localparam logic [PIX_Y_W-1:0] ORG_Y_Y   = PIX_Y_W'(ORG_Y);
    localparam logic [PIX_X_W-1:0] COL_X0_X  = PIX_X_W'(COL_X0);
    localparam logic [PIX_Y_W-1:0] COL_Y0_Y  = PIX_Y_W'(COL_Y0);
    localparam logic [PIX_Y_W-1:0] COL_Y1_Y  = PIX_Y_W'(COL_Y1);
    localparam logic [PIX_X_W-1:0] COL_SZ_X  = PIX_X_W'(COLON_SZ);
    localparam logic [PIX_Y_W-1:0] COL_SZ_Y  = PIX_Y_W'(COLON_SZ);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BLINK_FRAMES - 1);

    // Per-pixel flags that travel alongside the ROM access.
    typedef struct packed {
        logic             valid;
        logic             hit;
        logic             colon;
        logic             vis;
        logic [NUM_W-1:0] num;
    } pipe_t;

    logic [15:0]      shadow;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;

    logic [PIX_Y_W-1:0] dy;
    logic               y_in;
    logic [3:0]         slot_hit;
    logic [3:0]         slot_vis;
    logic [3:0][PIX_X_W-1:0] slot_px;
    logic [3:0][NUM_W-1:0]   slot_num;

    logic [PIX_X_W-1:0] colon_dx;
    logic [PIX_Y_W-1:0] colon_dy0;
    logic [PIX_Y_W-1:0] colon_dy1;
    logic               colon_hit;

    pipe_t              s1_d;
    pipe_t              s1_q;
    pipe_t [ROM_LAT-1:0] dly_q;
    pipe_t              out_st;

    // Unsigned wrap makes "x - origin < width" a complete range test.
    assign dy   = pix_y_i - ORG_Y_Y;
    assign y_in = dy < DIG_H_Y;

    for (genvar k = 0; k < 4; k++) begin : g_slot
        localparam logic [PIX_X_W-1:0] X0 = PIX_X_W'(ORG_X + k * SLOT_PITCH);
        logic [3:0]         digit;
        logic [PIX_X_W-1:0] dx;

        // Screen slot 0 (leftmost, hours tens) holds the top nibble.
        assign digit       = shadow[15-4*k -: 4];
        assign dx          = pix_x_i - X0;
        assign slot_hit[k] = pix_valid_i && (dx < DIG_W_X) && y_in;
        assign slot_vis[k] = (digit <= 4'd9)
                           && !(blink_en_i && blink_phase && blink_mask_i[k])
                           && !(LZ_SUPPRESS && (k == 0) && (digit == 4'd0));
        assign slot_px[k]  = slot_hit[k] ? dx : '0;
        assign slot_num[k] = slot_hit[k] ? NUM_W'(digit) : '0;
    end

    assign colon_dx  = pix_x_i - COL_X0_X;
    assign colon_dy0 = pix_y_i - COL_Y0_Y;
    assign colon_dy1 = pix_y_i - COL_Y1_Y;
    assign colon_hit = pix_valid_i && (colon_dx < COL_SZ_X)
                     && ((colon_dy0 < COL_SZ_Y) || (colon_dy1 < COL_SZ_Y));

    // Slots are disjoint, so at most one term of each OR is non-zero.
    assign s1_d = '{
        valid: pix_valid_i,
        hit:   |slot_hit,
        colon: colon_hit,
        vis:   |(slot_hit & slot_vis),
        num:   slot_num[0] | slot_num[1] | slot_num[2] | slot_num[3]
    };

    // Frame-synchronous digit latch and BCD validity flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_i) begin
            shadow    <= '0;
            bcd_err_o <= 1'b0;
        end else if (frame_start_i) begin
            shadow    <= time_digits_i;
            bcd_err_o <= (time_digits_i[15:12] > 4'd9) || (time_digits_i[11:8] > 4'd9)
                      || (time_digits_i[7:4]   > 4'd9) || (time_digits_i[3:0]  > 4'd9);
        end
    end

    // Blink half-period counter; leaving edit mode restarts from visible.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!blink_en_i) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start_i) begin
            if (blink_cnt == CNT_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
        end
    end

    // S1: ROM address and pixel flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: every pipeline flag is reset so pixels in flight are dropped.
        if (!rst_i) begin
            pos_x_o <= '0;
            pos_y_o <= '0;
            s1_q    <= '0;
        end else begin
            pos_x_o <= slot_px[0] | slot_px[1] | slot_px[2] | slot_px[3];
            pos_y_o <= (|slot_hit) ? dy : '0;
            s1_q    <= s1_d;
        end
    end

    // Delay line matching the ROM read latency.
    if (ROM_LAT == 1) begin : g_lat1
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) dly_q <= '0;
            else        dly_q <= s1_q;
        end
    end else begin : g_latn
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) dly_q <= '0;
            else        dly_q <= {dly_q[ROM_LAT-2:0], s1_q};
        end
    end

    assign out_st = dly_q[ROM_LAT-1];
    // The ROM output mux selects the glyph whose address produced pix_i.
    assign num_o  = out_st.num;

    // S2: combine the ROM bit with visibility; the colon ignores the ROM.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pix_valid_o <= 1'b0;
            pix_on_o    <= 1'b0;
        end else begin
            pix_valid_o <= out_st.valid;
            pix_on_o    <= out_st.valid
                        && ((out_st.hit && out_st.vis && pix_i) || out_st.colon);
        end
    end

endmodule

// File: tb/tb_clock_digits_scheduler.sv
// Scoreboard bench for clock_digits_scheduler with a fake glyph ROM.
module tb_clock_digits_scheduler;

    localparam int BF = 2;

    logic        clk_i         = 1'b0;
    logic        rst_i         = 1'b1;
    logic        frame_start_i = 1'b0;
    logic        pix_valid_i   = 1'b0;
    logic [11:0] pix_x_i       = '0;
    logic [11:0] pix_y_i       = '0;
    logic [15:0] time_digits_i = '0;
    logic        blink_en_i    = 1'b0;
    logic [3:0]  blink_mask_i  = '0;
    logic [3:0]  num_o;
    logic [11:0] pos_x_o;
    logic [11:0] pos_y_o;
    logic        pix_i;
    logic        pix_valid_o;
    logic        pix_on_o;
    logic        bcd_err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    clock_digits_scheduler #(.BLINK_FRAMES(BF)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .frame_start_i (frame_start_i),
        .pix_valid_i   (pix_valid_i),
        .pix_x_i       (pix_x_i),
        .pix_y_i       (pix_y_i),
        .time_digits_i (time_digits_i),
        .blink_en_i    (blink_en_i),
        .blink_mask_i  (blink_mask_i),
        .num_o         (num_o),
        .pos_x_o       (pos_x_o),
        .pos_y_o       (pos_y_o),
        .pix_i         (pix_i),
        .pix_valid_o   (pix_valid_o),
        .pix_on_o      (pix_on_o),
        .bcd_err_o     (bcd_err_o)
    );

    // Arbitrary glyph pattern standing in for the num_to_pix ROM contents.
    function automatic logic glyph(input logic [3:0] n, input logic [11:0] x, input logic [11:0] y);
        return 4'(x[3:0] + y[3:0]) != n;
    endfunction

    // Fake ROM with one cycle of address latency; num_o drives its output mux.
    logic [11:0] rom_x_q = '0;
    logic [11:0] rom_y_q = '0;
    always @(posedge clk_i) begin
        rom_x_q <= pos_x_o;
        rom_y_q <= pos_y_o;
    end
    assign pix_i = glyph(num_o, rom_x_q, rom_y_q);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [11:0] px;
        logic [11:0] py;
        logic [3:0]  num;
        logic        valid;
        logic        on;
        logic        err;
    } exp_t;

    exp_t sb[$];

    // Reference model state.
    logic [15:0] m_shadow;
    int          m_cnt;
    logic        m_phase;
    logic        m_err;

    function automatic logic bcd_bad(input logic [15:0] t);
        for (int k = 0; k < 4; k++)
            if (4'(t >> (4 * k)) > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model_pix(input logic v, input int x, input int y);
        exp_t       e;
        logic [3:0] d;
        logic       vis;
        int         x0;
        e = '{default: '0};
        if (v) begin
            e.valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                x0 = 100 + 112 * k;
                if (x >= x0 && x < x0 + 80 && y >= 180 && y < 300) begin
                    d     = 4'(m_shadow >> (12 - 4 * k));
                    e.px  = 12'(x - x0);
                    e.py  = 12'(y - 180);
                    e.num = d;
                    vis   = (d <= 4'd9)
                          && !(blink_en_i && m_phase && (((blink_mask_i >> k) & 4'd1) != 4'd0))
                          && !(k == 0 && d == 4'd0);
                    e.on  = vis && glyph(d, e.px, e.py);
                end
            end
            if (x >= 302 && x < 314 && ((y >= 214 && y < 226) || (y >= 254 && y < 266)))
                e.on = 1'b1;
        end
        return e;
    endfunction

    task automatic reset_model();
        exp_t z;
        z        = '{default: '0};
        m_shadow = '0;
        m_cnt    = 0;
        m_phase  = 1'b0;
        m_err    = 1'b0;
        sb.delete();
        repeat (3) sb.push_back(z);
    endtask

    // One scan cycle: drive inputs, push the expectation, advance the model.
    task automatic drive(input logic v, input int x, input int y, input logic fs);
        exp_t e;
        pix_valid_i   = v;
        pix_x_i       = 12'(x);
        pix_y_i       = 12'(y);
        frame_start_i = fs;
        e = model_pix(v, x, y);
        if (fs) begin
            m_shadow = time_digits_i;
            m_err    = bcd_bad(time_digits_i);
        end
        if (!blink_en_i) begin
            m_cnt   = 0;
            m_phase = 1'b0;
        end else if (fs) begin
            if (m_cnt == BF - 1) begin
                m_cnt   = 0;
                m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
        end
        e.err = m_err;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic pix(input int x, input int y);
        drive(1'b1, x, y, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 1'b0);
    endtask

    task automatic frame();
        drive(1'b0, 0, 0, 1'b1);
    endtask

    task automatic slot_row();
        for (int k = 0; k < 4; k++) pix(110 + 112 * k, 190);
        pix(305, 220);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_num"},   32'(num_o),       32'd0);
        check({tag, "_pos_x"}, 32'(pos_x_o),     32'd0);
        check({tag, "_pos_y"}, 32'(pos_y_o),     32'd0);
        check({tag, "_valid"}, 32'(pix_valid_o), 32'd0);
        check({tag, "_on"},    32'(pix_on_o),    32'd0);
        check({tag, "_err"},   32'(bcd_err_o),   32'd0);
    endtask

    // Sampled mid-cycle: newest entry is the sample about to be captured,
    // so S1 outputs match sb[2], num_o sb[1] and the final stage sb[0].
    always @(negedge clk_i) begin
        if (rst_i && sb.size() == 4) begin
            check("pos_x",     32'(pos_x_o),     32'(sb[2].px));
            check("pos_y",     32'(pos_y_o),     32'(sb[2].py));
            check("bcd_err",   32'(bcd_err_o),   32'(sb[2].err));
            check("num",       32'(num_o),       32'(sb[1].num));
            check("pix_valid", 32'(pix_valid_o), 32'(sb[0].valid));
            check("pix_on",    32'(pix_on_o),    32'(sb[0].on));
            sb.delete(0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        #3 rst_i = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        reset_model();

        // First pixel after reset: slot 0, shadow still zero.
        pix(105, 187);
        idle(3);

        // Latch 1234 and probe slots, gap, a ROM-zero point and the colon.
        time_digits_i = 16'h1234;
        frame();
        pix(334, 190);
        pix(180, 190);
        pix(325, 182);
        pix(305, 220);
        pix(305, 240);
        pix(305, 260);
        pix(313, 225);
        pix(314, 225);
        idle(2);

        // Mid-frame change must not tear; pixel on frame_start sees old digits.
        time_digits_i = 16'h5678;
        slot_row();
        drive(1'b1, 110, 190, 1'b1);
        slot_row();
        idle(2);

        // Blinking slots 0 and 1 across six frames.
        blink_en_i   = 1'b1;
        blink_mask_i = 4'b0011;
        for (int f = 0; f < 6; f++) begin
            slot_row();
            frame();
        end
        slot_row();
        blink_en_i = 1'b0;
        slot_row();
        idle(2);

        // Invalid BCD digit and leading-zero suppression.
        time_digits_i = 16'h0A59;
        frame();
        slot_row();
        time_digits_i = 16'h1059;
        frame();
        slot_row();
        idle(2);

        // Reset mid-line with pixels in flight.
        time_digits_i = 16'h1234;
        frame();
        pix(110, 190);
        pix(222, 190);
        pix(334, 190);
        rst_i = 1'b0;
        #1 check_all_zero("midreset");
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        reset_model();
        pix(446, 190);
        pix(305, 220);
        pix(222, 190);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
